// File: rtl/uart_pkg.sv
// Shared UART definitions: timing defaults, ASCII constants, TX state encoding
// and the decimal digit helper used by the status report.
package uart_pkg;

    localparam int DELAY_FRAMES_DEFAULT = 234;
    localparam int MSG_LEN              = 25;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_H     = 8'h48;
    localparam logic [7:0] ASCII_P     = 8'h50;
    localparam logic [7:0] ASCII_G     = 8'h47;
    localparam logic [7:0] ASCII_E     = 8'h45;
    localparam logic [7:0] ASCII_S     = 8'h53;
    localparam logic [7:0] ASCII_Z     = 8'h5A;
    localparam logic [7:0] ASCII_A     = 8'h41;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef struct packed {
        logic [4:0] hunger;
        logic [4:0] happiness;
        logic [4:0] hygiene;
        logic [4:0] energy;
        logic       sleeping;
    } stats_t;

    // Returns {tens, ones} as ASCII; a 5-bit value never exceeds 31, so tens is 0..3.
    function automatic logic [15:0] to_ascii2(input logic [4:0] v);
        logic [4:0] tens;
        logic [4:0] ones;
        tens = (v >= 5'd30) ? 5'd3 :
               (v >= 5'd20) ? 5'd2 :
               (v >= 5'd10) ? 5'd1 : 5'd0;
        ones = v - 5'(tens * 5'd10);
        return {ASCII_0 + {3'b000, tens}, ASCII_0 + {3'b000, ones}};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a valid/ready handshake; ready is also raised in the
// final stop-bit cycle so consecutive bytes leave with no idle gap.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int DELAY_FRAMES = DELAY_FRAMES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam int              CNT_W   = (DELAY_FRAMES > 1) ? $clog2(DELAY_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DELAY_FRAMES - 1);

    tx_state_t        state;
    tx_state_t        state_next;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       byte_q;
    logic             bit_end;

    assign bit_end = (cnt == CNT_MAX);

    // NOTE: state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= TX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            byte_q  <= '0;
        end else begin
            state <= state_next;
            cnt   <= (state == TX_IDLE || bit_end) ? '0 : cnt + 1'b1;
            if (state != TX_DATA)
                bit_idx <= '0;
            else if (bit_end)
                bit_idx <= bit_idx + 1'b1;
            if (valid && ready)
                byte_q <= data;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            TX_IDLE:  if (valid) state_next = TX_START;
            TX_START: if (bit_end) state_next = TX_DATA;
            TX_DATA:  if (bit_end && bit_idx == 3'd7) state_next = TX_STOP;
            TX_STOP:  if (bit_end) state_next = valid ? TX_START : TX_IDLE;
            default:  state_next = TX_IDLE;
        endcase
    end

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        tx    = 1'b1;
        ready = 1'b0;
        case (state)
            TX_IDLE:  ready = 1'b1;
            TX_START: tx    = 1'b0;
            TX_DATA:  tx    = byte_q[bit_idx];
            TX_STOP:  ready = bit_end;
            default:  ;
        endcase
    end

endmodule

// File: rtl/uart_status_tx.sv
// Sends one 25-byte ASCII report "H:hh P:pp G:gg E:ee S:s\r\n" per accepted start,
// built from a snapshot of the pet stats taken on the accepting edge.
module uart_status_tx
    import uart_pkg::*;
#(
    parameter int DELAY_FRAMES = DELAY_FRAMES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] hunger,
    input  logic [4:0] happiness,
    input  logic [4:0] hygiene,
    input  logic [4:0] energy,
    input  logic       is_sleeping,
    output logic       uart_tx,
    output logic       busy,
    output logic       done
);

    localparam logic [4:0] LAST_IDX = 5'(MSG_LEN - 1);

    stats_t     live;
    stats_t     snap;
    stats_t     cur;
    logic [4:0] idx;
    logic [4:0] cur_idx;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;

    function automatic logic [7:0] msg_byte(input logic [4:0] i, input stats_t s);
        logic [15:0] hh;
        logic [15:0] pp;
        logic [15:0] gg;
        logic [15:0] ee;
        hh = to_ascii2(s.hunger);
        pp = to_ascii2(s.happiness);
        gg = to_ascii2(s.hygiene);
        ee = to_ascii2(s.energy);
        case (i)
            5'd0:  return ASCII_H;
            5'd1:  return ASCII_COLON;
            5'd2:  return hh[15:8];
            5'd3:  return hh[7:0];
            5'd4:  return ASCII_SPACE;
            5'd5:  return ASCII_P;
            5'd6:  return ASCII_COLON;
            5'd7:  return pp[15:8];
            5'd8:  return pp[7:0];
            5'd9:  return ASCII_SPACE;
            5'd10: return ASCII_G;
            5'd11: return ASCII_COLON;
            5'd12: return gg[15:8];
            5'd13: return gg[7:0];
            5'd14: return ASCII_SPACE;
            5'd15: return ASCII_E;
            5'd16: return ASCII_COLON;
            5'd17: return ee[15:8];
            5'd18: return ee[7:0];
            5'd19: return ASCII_SPACE;
            5'd20: return ASCII_S;
            5'd21: return ASCII_COLON;
            5'd22: return s.sleeping ? ASCII_Z : ASCII_A;
            5'd23: return ASCII_CR;
            default: return ASCII_LF;
        endcase
    endfunction

    assign live = {hunger, happiness, hygiene, energy, is_sleeping};

    // While idle the first byte is offered straight from the live inputs, so the
    // serializer and the snapshot both load on the accepting edge.
    always_comb begin
        cur      = busy ? snap : live;
        cur_idx  = busy ? idx + 5'd1 : 5'd0;
        tx_valid = busy ? (idx != LAST_IDX) : start;
        tx_data  = msg_byte(cur_idx, cur);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            idx  <= '0;
            snap <= '0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy <= 1'b1;
                    snap <= live;
                    idx  <= '0;
                end
            end else if (tx_ready) begin
                if (idx == LAST_IDX) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    idx <= idx + 5'd1;
                end
            end
        end
    end

    uart_tx_byte #(
        .DELAY_FRAMES(DELAY_FRAMES)
    ) u_tx_byte (
        .clk  (clk),
        .rst  (rst),
        .valid(tx_valid),
        .data (tx_data),
        .ready(tx_ready),
        .tx   (uart_tx)
    );

endmodule

// File: tb/tb_uart_status_tx.sv
// Bench for uart_status_tx: a report-level model predicts the line every cycle,
// a line decoder recovers bytes, and directed tests pin literal reports and timing.
module tb_uart_status_tx;

    localparam int DF     = 4;
    localparam int REPORT = 25 * 10 * DF;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] hunger;
    logic [4:0] happiness;
    logic [4:0] hygiene;
    logic [4:0] energy;
    logic       is_sleeping;
    logic       uart_tx;
    logic       busy;
    logic       done;

    uart_status_tx #(.DELAY_FRAMES(DF)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .hunger     (hunger),
        .happiness  (happiness),
        .hygiene    (hygiene),
        .energy     (energy),
        .is_sleeping(is_sleeping),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic string vis(input string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h0D)      r = {r, "<CR>"};
            else if (s[i] == 8'h0A) r = {r, "<LF>"};
            else                    r = {r, $sformatf("%c", s[i])};
        end
        return r;
    endfunction

    task automatic check_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, vis(act), vis(exp));
        end
    endtask

    // Report-level model: text from the stats, then a start/8 data/stop bit list.
    function automatic string report_text(input logic [4:0] h, input logic [4:0] p,
                                          input logic [4:0] g, input logic [4:0] e,
                                          input logic s);
        return $sformatf("H:%02d P:%02d G:%02d E:%02d S:%s\r\n", h, p, g, e, s ? "Z" : "A");
    endfunction

    function automatic logic [249:0] report_bits(input string msg);
        logic [249:0] b;
        logic [7:0]   c;
        b = '0;
        for (int f = 0; f < 25; f++) begin
            c = msg[f];
            b[f*10] = 1'b0;
            for (int j = 0; j < 8; j++) b[f*10+1+j] = c[j];
            b[f*10+9] = 1'b1;
        end
        return b;
    endfunction

    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    int           m_pos  = 0;
    logic [249:0] m_bits = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_pos  <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_pos == REPORT - 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
                m_pos <= m_pos + 1;
            end else if (start) begin
                m_busy <= 1'b1;
                m_pos  <= 0;
                m_bits <= report_bits(report_text(hunger, happiness, hygiene, energy, is_sleeping));
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("uart_tx", {31'd0, uart_tx}, {31'd0, m_busy ? m_bits[m_pos/DF] : 1'b1});
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            check("done", {31'd0, done}, {31'd0, m_done});
        end
    end

    // Line decoder: samples mid-bit, pushes each completed byte.
    logic [7:0] rx_q[$];
    logic [7:0] rx_sh  = '0;
    bit         rx_act = 1'b0;
    int         rx_ph  = 0;

    always @(negedge clk) begin
        if (rst) begin
            rx_act <= 1'b0;
        end else if (!rx_act) begin
            if (uart_tx === 1'b0) begin
                rx_act <= 1'b1;
                rx_ph  <= 1;
            end
        end else begin
            rx_ph <= rx_ph + 1;
            if (rx_ph % 4 == 2 && rx_ph >= 6 && rx_ph <= 34)
                rx_sh[(rx_ph-6)/4] <= uart_tx;
            if (rx_ph == 38) begin
                check("stop_bit", {31'd0, uart_tx}, 32'd1);
                rx_q.push_back(rx_sh);
            end
            if (rx_ph == 39) rx_act <= 1'b0;
        end
    end

    function automatic string rx_str();
        string s = "";
        foreach (rx_q[i]) s = {s, $sformatf("%c", rx_q[i])};
        return s;
    endfunction

    // Accept-to-done timing monitor.
    int cyc      = 0;
    int t_acc    = 0;
    int done_cnt = 0;
    int durs[$];
    logic busy_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (chk_en) begin
            if (busy === 1'b1 && busy_q !== 1'b1) t_acc <= cyc;
            if (done === 1'b1) begin
                done_cnt <= done_cnt + 1;
                durs.push_back(cyc - t_acc);
            end
            busy_q <= busy;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic set_stats(input logic [4:0] h, input logic [4:0] p, input logic [4:0] g,
                             input logic [4:0] e, input logic s);
        hunger = h; happiness = p; hygiene = g; energy = e; is_sleeping = s;
    endtask

    task automatic wait_done(input int target, input int bound);
        int n = 0;
        while (done_cnt < target && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("done_count", done_cnt, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int n;
        rst = 1'b1;
        start = 1'b0;
        set_stats(5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        step(2);
        chk_en = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        step(50);

        // Basic report and exact timing.
        set_stats(5'd7, 5'd12, 5'd3, 5'd31, 1'b0);
        check_str("model_text", report_text(hunger, happiness, hygiene, energy, is_sleeping),
                  "H:07 P:12 G:03 E:31 S:A\r\n");
        rx_q.delete(); durs.delete(); d0 = done_cnt;
        pulse_start();
        wait_done(d0 + 1, REPORT + 100);
        check("report1_cycles", durs.size() > 0 ? durs[0] : -1, 1000);
        check_str("report1_text", rx_str(), "H:07 P:12 G:03 E:31 S:A\r\n");
        step(5);

        // Snapshot holds while inputs change mid-report.
        set_stats(5'd0, 5'd9, 5'd10, 5'd19, 1'b1);
        rx_q.delete(); durs.delete(); d0 = done_cnt;
        pulse_start();
        step(4);
        set_stats(5'd21, 5'd30, 5'd1, 5'd2, 1'b0);
        wait_done(d0 + 1, REPORT + 100);
        check_str("snapshot_text", rx_str(), "H:00 P:09 G:10 E:19 S:Z\r\n");
        step(5);

        // Start while busy is ignored.
        set_stats(5'd25, 5'd5, 5'd16, 5'd8, 1'b0);
        rx_q.delete(); durs.delete(); d0 = done_cnt;
        pulse_start();
        n = 0;
        while (rx_q.size() < 3 && n < 200) begin step(1); n++; end
        check("reached_byte3", rx_q.size(), 3);
        pulse_start();
        wait_done(d0 + 1, REPORT + 100);
        check_str("ignore_start_text", rx_str(), "H:25 P:05 G:16 E:08 S:A\r\n");
        check("ignore_start_cycles", durs.size() > 0 ? durs[0] : -1, 1000);
        step(20);
        check("ignore_start_single_done", done_cnt - d0, 1);

        // Reset at byte 10, bit 4 aborts without done.
        set_stats(5'd14, 5'd27, 5'd22, 5'd6, 1'b0);
        d0 = done_cnt;
        pulse_start();
        step(420);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("abort_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        step(60);
        check("abort_no_done", done_cnt, d0);
        rx_q.delete(); durs.delete();
        pulse_start();
        wait_done(d0 + 1, REPORT + 100);
        check("after_abort_bytes", rx_q.size(), 25);
        check_str("after_abort_text", rx_str(), "H:14 P:27 G:22 E:06 S:A\r\n");
        step(5);

        // Start held high: back-to-back reports.
        set_stats(5'd31, 5'd31, 5'd0, 5'd1, 1'b1);
        rx_q.delete(); durs.delete(); d0 = done_cnt;
        start = 1'b1;
        wait_done(d0 + 3, 3 * REPORT + 100);
        start = 1'b0;
        step(50);
        check("b2b_no_fourth", done_cnt, d0 + 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("b2b_cycles_%0d", i), durs.size() > i ? durs[i] : -1, 1000);
        check_str("b2b_text", rx_str(),
                  {"H:31 P:31 G:00 E:01 S:Z\r\n", "H:31 P:31 G:00 E:01 S:Z\r\n",
                   "H:31 P:31 G:00 E:01 S:Z\r\n"});

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
